// File: rtl/tdm_demux.sv
// TDM demultiplexer: N slots of W bits per frame, sof-aligned, lock FSM.
// Define TDM_DEMUX_STRICT_SOF_EN to demand sof on every slot-0 beat.
module tdm_demux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 sof,
  output logic [N*W-1:0]       ch_data,
  output logic                 frame_valid,
  output logic [$clog2(N)-1:0] slot,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t         state, state_n;
  logic [SW-1:0]  slot_n;
  logic [W-1:0]   shadow   [N-1];
  logic [W-1:0]   shadow_n [N-1];
  logic [N*W-1:0] ch_n;
  logic           fv_n, se_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < N - 1; k++)
        shadow[k] <= '0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      ch_data     <= ch_n;
      frame_valid <= fv_n;
      sync_err    <= se_n;
      shadow      <= shadow_n;
    end
  end

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    shadow_n = shadow;
    ch_n     = ch_data;
    fv_n     = 1'b0;
    se_n     = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sof) begin
            shadow_n[0] = din;
            slot_n      = SW'(1);
            state_n     = RECV;
          end
        end
        RECV: begin
          unique case (1'b1)
            (sof && slot != '0): begin
              // early sof: drop partial frame, resync here
              se_n        = 1'b1;
              shadow_n[0] = din;
              slot_n      = SW'(1);
            end
            (slot == '0): begin
`ifdef TDM_DEMUX_STRICT_SOF_EN
              if (sof) begin
                shadow_n[0] = din;
                slot_n      = SW'(1);
              end else begin
                se_n    = 1'b1;
                slot_n  = '0;
                state_n = HUNT;
              end
`else
              shadow_n[0] = din;
              slot_n      = SW'(1);
`endif
            end
            (slot == LAST): begin
              for (int k = 0; k < N - 1; k++)
                ch_n[k*W +: W] = shadow[k];
              ch_n[(N-1)*W +: W] = din;
              fv_n   = 1'b1;
              slot_n = '0;
            end
            default: begin
              shadow_n[slot] = din;
              slot_n         = slot + SW'(1);
            end
          endcase
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux (N=4, W=8).
// Covers both TDM_DEMUX_STRICT_SOF_EN builds.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic [31:0] ch_data;
  logic        frame_valid;
  logic [1:0]  slot;
  logic        locked;
  logic        sync_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .sof(sof), .ch_data(ch_data), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  // {frame_valid, sync_err, locked, slot}
  function automatic logic [4:0] flags();
    return {frame_valid, sync_err, locked, slot};
  endfunction

  task automatic beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    din = d; sof = s; din_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; sof = 1'b1; din = 8'hEE;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (flags() !== 5'b00000 || ch_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset: flags=%b ch=%h want 00000 00000000", flags(), ch_data);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_hunt();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    n_cmp++;
    if (flags() !== 5'b00000) begin
      n_err++;
      $display("FAIL hunt_discard: flags=%b want 00000", flags());
    end
  endtask

  task automatic test_frame();
    beat(8'h11, 1'b1);
    n_cmp++;
    if (flags() !== 5'b00101) begin
      n_err++;
      $display("FAIL lock: flags=%b want 00101", flags());
    end
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    n_cmp++;
    if (flags() !== 5'b00111 || ch_data !== 32'h0) begin
      n_err++;
      $display("FAIL mid_frame: flags=%b ch=%h want 00111 0", flags(), ch_data);
    end
    beat(8'h44, 1'b0);
    n_cmp++;
    if (flags() !== 5'b10100 || ch_data !== 32'h44332211) begin
      n_err++;
      $display("FAIL frame: flags=%b ch=%h want 10100 44332211", flags(), ch_data);
    end
    idle(1);
    n_cmp++;
    if (flags() !== 5'b00100) begin
      n_err++;
      $display("FAIL fv_pulse: flags=%b want 00100", flags());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        v = 8'(8'h60 + 8'(f * 16) + 8'(i));
        beat(v, i == 0);
      end
      n_cmp++;
      if (flags() !== 5'b10100 ||
          ch_data !== (32'h63626160 + 32'(f) * 32'h10101010)) begin
        n_err++;
        $display("FAIL back_to_back%0d: flags=%b ch=%h", f, flags(), ch_data);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    idle(1);
    for (int i = 0; i < 4; i++) begin
      beat(d[i], i == 0);
      if (i < 3) begin
        idle(3);
        n_cmp++;
        if (flags() !== {3'b001, 2'(i + 1)}) begin
          n_err++;
          $display("FAIL gap_hold%0d: flags=%b want 001%b", i, flags(), 2'(i + 1));
        end
      end
    end
    n_cmp++;
    if (flags() !== 5'b10100 || ch_data !== 32'h44332211) begin
      n_err++;
      $display("FAIL gap_frame: flags=%b ch=%h want 10100 44332211", flags(), ch_data);
    end
  endtask

  task automatic test_early_sof();
    beat(8'hAA, 1'b1);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    n_cmp++;
    if (flags() !== 5'b01101 || ch_data !== 32'h44332211) begin
      n_err++;
      $display("FAIL early_sof: flags=%b ch=%h want 01101 44332211", flags(), ch_data);
    end
    beat(8'hDD, 1'b0);
    n_cmp++;
    if (flags() !== 5'b00110) begin
      n_err++;
      $display("FAIL err_pulse: flags=%b want 00110", flags());
    end
    beat(8'hEE, 1'b0);
    beat(8'hFF, 1'b0);
    n_cmp++;
    if (flags() !== 5'b10100 || ch_data !== 32'hFFEEDDCC) begin
      n_err++;
      $display("FAIL resync_frame: flags=%b ch=%h want 10100 FFEEDDCC", flags(), ch_data);
    end
  endtask

  task automatic test_slot0_nosof();
    beat(8'h55, 1'b0);
`ifdef TDM_DEMUX_STRICT_SOF_EN
    n_cmp++;
    if (flags() !== 5'b01000 || ch_data !== 32'hFFEEDDCC) begin
      n_err++;
      $display("FAIL strict_slot0: flags=%b ch=%h want 01000 FFEEDDCC", flags(), ch_data);
    end
`else
    n_cmp++;
    if (flags() !== 5'b00101) begin
      n_err++;
      $display("FAIL free_slot0: flags=%b want 00101", flags());
    end
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b0);
    beat(8'h88, 1'b0);
    n_cmp++;
    if (flags() !== 5'b10100 || ch_data !== 32'h88776655) begin
      n_err++;
      $display("FAIL free_frame: flags=%b ch=%h want 10100 88776655", flags(), ch_data);
    end
`endif
  endtask

  task automatic test_async_reset();
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (flags() !== 5'b00000 || ch_data !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: flags=%b ch=%h want 00000 0", flags(), ch_data);
    end
    @(negedge clk); rst_n = 1'b1;
    test_hunt();
    beat(8'hA1, 1'b1);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b0);
    beat(8'hA4, 1'b0);
    n_cmp++;
    if (flags() !== 5'b10100 || ch_data !== 32'hA4A3A2A1) begin
      n_err++;
      $display("FAIL post_reset_frame: flags=%b ch=%h want 10100 A4A3A2A1", flags(), ch_data);
    end
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_frame();
    test_back_to_back();
    test_gaps();
    test_early_sof();
    test_slot0_nosof();
    test_async_reset();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives a single W-bit stream carrying N channel slots per frame, with a start-of-frame marker on slot 0, and distributes each frame into N parallel registered channel outputs. It is the receiving end of the slot-multiplexed link driven by the team's mux-based serializer, and feeds the per-channel display/processing logic. A two-state lock FSM tracks frame alignment and flags sync errors.

## Interface
- N, 4, channels per frame (≥2); slot counter width is $clog2(N)
- W, 8, data bits per slot
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  W  slot data
- din_valid  in  1  din carries a slot this cycle; low = idle gap, no state advance
- sof  in  1  start of frame; meaningful only when din_valid=1
- ch_data  out  N*W  channel k occupies bits [k*W +: W]; updated only on frame completion
- frame_valid  out  1  one-cycle pulse: ch_data just updated with a complete frame
- slot  out  $clog2(N)  index the next accepted beat will be written to
- locked  out  1  FSM in RECV
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- Reset (rst_n=0, asynchronous): state HUNT, slot=0, locked=0, ch_data=0, shadow=0, frame_valid=0, sync_err=0. Reset mid-frame discards the partial frame; ch_data returns to 0.
- HUNT: beats with din_valid=1, sof=0 discarded. Beat with din_valid=1, sof=1 → written to shadow slot 0, slot=1, state RECV.
- RECV, beat accepted at slot s (din_valid=1):
  - 0<s<N-1, sof=0: shadow[s]<=din, slot<=s+1.
  - s=N-1, sof=0: ch_data<={din, shadow[N-2..0]}, frame_valid pulses, slot wraps to 0, stays RECV.
  - s≠0, sof=1 (early sof): sync_err pulses, partial frame dropped (ch_data unchanged), beat taken as new slot 0, slot<=1, stays RECV.
  - s=0, sof=1: normal, shadow[0]<=din, slot<=1.
  - s=0, sof=0: see Configuration.
- din_valid=0: nothing changes; gaps of any length allowed anywhere in a frame.
- frame_valid and sync_err never assert in the same cycle.
- sof with din_valid=0 is ignored.

## Timing
- All outputs registered. frame_valid and the new ch_data appear in the cycle after the edge that accepts slot N-1 (latency 1 clock from last beat).
- Minimum frame duration N cycles; back-to-back frames give frame_valid every N cycles with no bubble.
- sync_err asserts in the cycle after the offending beat's edge, for exactly one cycle.
- slot and locked reflect the state after each edge; slot=0 in HUNT.
- Throughput: one beat per cycle; no backpressure output.

## Configuration
- TDM_DEMUX_STRICT_SOF_EN defined: in RECV, a beat at slot 0 with sof=0 is a violation → sync_err pulses, beat discarded, state HUNT, slot=0, locked=0; ch_data holds.
- Not defined: such a beat is accepted as slot 0 (free-running after first lock), no error; sof is required only to leave HUNT and for early-sof resync.

## Test plan
- Reset then N=4,W=8: beats 0x11(sof),0x22,0x33,0x44 back-to-back → one cycle later ch_data=0x44332211, frame_valid=1 for one cycle, slot=0, locked=1.
- Same frame with din_valid=0 gaps of 3 cycles between beats → identical ch_data, frame_valid only after 0x44, slot holds during gaps.
- Beats 0xAA(sof),0xBB, then 0xCC(sof),0xDD,0xEE,0xFF → sync_err one pulse after 0xCC, no frame_valid for partial, then ch_data=0xFFEEDDCC.
- After a complete frame, next beat 0x55 with sof=0 → strict build: sync_err, locked=0, slot=0, ch_data unchanged; non-strict build: no error, 0x55 lands in channel 0 of next frame.
- Assert rst_n=0 asynchronously (mid-cycle) after 2 beats of a frame → ch_data=0, locked=0, slot=0 immediately; following sof frame received correctly.
- Beats with sof=0 while in HUNT (0x01,0x02) → discarded, slot stays 0, no pulses.
